// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - Shared state type, EEPROM constants and SPI word builder for the dump sequencer.
// Optional feature macro: DUMP_CHKSUM_EN (adds the checksum states).
package dump_pkg;

  typedef enum logic [3:0] {
    IDLE,
    OFF_A,
    OFF_B,
    GN_A,
    GN_B,
    RD,
    SEND,
    WAIT,
`ifdef DUMP_CHKSUM_EN
    CHK,
    CHK_WAIT,
`endif
    DONE
  } dump_state_t;

  localparam logic [2:0] EEP_SS     = 3'b100;
  localparam logic [1:0] EEP_RD_CMD = 2'b00;
  localparam logic       SEL_OFFSET = 1'b0;
  localparam logic       SEL_GAIN   = 1'b1;

  // First word of a two-transfer EEPROM read; the second transfer is all zeros.
  function automatic logic [15:0] eep_read_word(input logic [1:0] ch, input logic [2:0] gain,
                                                input logic sel);
    return {EEP_RD_CMD, ch, gain, sel, 8'h00};
  endfunction

endpackage

// File: rtl/dump_addr_gen.sv
// rtl/dump_addr_gen.sv - Capture RAM walk: start latch, wrapping read address, sample counter, last flag.
module dump_addr_gen #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic              load,
  input  logic              step,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              last
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  logic [ADDR_W-1:0] start;
  logic [ADDR_W:0]   cnt;

  // Oldest sample sits just after the newest one; the address width gives the wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start    <= '0;
      ram_addr <= '0;
      cnt      <= '0;
    end else begin
      if (accept) start <= trace_end + 1'b1;
      if (load) ram_addr <= start;
      else if (step && !last) ram_addr <= ram_addr + 1'b1;
      if (clear) cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/dump_sequencer.sv
// rtl/dump_sequencer.sv - Channel dump: EEPROM offset/gain fetch over SPI, then capture RAM walk to UART.
// Optional feature macro: DUMP_CHKSUM_EN (mod-256 checksum byte after the last sample).
module dump_sequencer
  import dump_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump,
  input  logic [1:0]        dump_ch,
  input  logic [8:0]        ch_gain,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic              SPI_done,
  input  logic              resp_sent,
  input  logic [7:0]        corrected,
  output logic              wrt_SPI,
  output logic [15:0]       SPI_data,
  output logic [2:0]        ss,
  output logic              flopOffset,
  output logic              flopGain,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2:0]        ram_en,
  output logic              send_resp,
  output logic              dump_busy,
`ifdef DUMP_CHKSUM_EN
  output logic              chk_sel,
  output logic [7:0]        chk_byte,
`endif
  output logic              dump_done
);

  dump_state_t state, state_d;
  logic [1:0]  ch_q;
  logic [2:0]  gain_q, gain_in;
  logic        wrt_d, flop_off_d, flop_gain_d;
  logic [15:0] spi_data_d;
  logic        accept, load, step, last, clear;

  always_comb begin
    case (dump_ch)
      2'd0:    gain_in = ch_gain[2:0];
      2'd1:    gain_in = ch_gain[5:3];
      default: gain_in = ch_gain[8:6];
    endcase
  end

  assign clear = (state == IDLE);

  dump_addr_gen #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .accept   (accept),
    .trace_end(trace_end),
    .load     (load),
    .step     (step),
    .ram_addr (ram_addr),
    .last     (last)
  );

  always_comb begin
    state_d     = state;
    wrt_d       = 1'b0;
    spi_data_d  = SPI_data;
    flop_off_d  = 1'b0;
    flop_gain_d = 1'b0;
    accept      = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      IDLE: if (dump && dump_ch != 2'b11) begin
        accept     = 1'b1;
        wrt_d      = 1'b1;
        spi_data_d = eep_read_word(dump_ch, gain_in, SEL_OFFSET);
        state_d    = OFF_A;
      end
      OFF_A: if (SPI_done) begin
        wrt_d      = 1'b1;
        spi_data_d = 16'h0000;
        state_d    = OFF_B;
      end
      OFF_B: if (SPI_done) begin
        flop_off_d = 1'b1;
        wrt_d      = 1'b1;
        spi_data_d = eep_read_word(ch_q, gain_q, SEL_GAIN);
        state_d    = GN_A;
      end
      GN_A: if (SPI_done) begin
        wrt_d      = 1'b1;
        spi_data_d = 16'h0000;
        state_d    = GN_B;
      end
      GN_B: if (SPI_done) begin
        flop_gain_d = 1'b1;
        load        = 1'b1;
        state_d     = RD;
      end
      RD:   state_d = SEND;
      SEND: state_d = WAIT;
      WAIT: if (resp_sent) begin
        step = 1'b1;
`ifdef DUMP_CHKSUM_EN
        state_d = last ? CHK : RD;
`else
        state_d = last ? DONE : RD;
`endif
      end
`ifdef DUMP_CHKSUM_EN
      CHK:      state_d = CHK_WAIT;
      CHK_WAIT: if (resp_sent) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch_q       <= '0;
      gain_q     <= '0;
      wrt_SPI    <= 1'b0;
      SPI_data   <= '0;
      ss         <= EEP_SS;
      flopOffset <= 1'b0;
      flopGain   <= 1'b0;
    end else begin
      state      <= state_d;
      wrt_SPI    <= wrt_d;
      SPI_data   <= spi_data_d;
      flopOffset <= flop_off_d;
      flopGain   <= flop_gain_d;
      if (wrt_d) ss <= EEP_SS;
      if (accept) begin
        ch_q   <= dump_ch;
        gain_q <= gain_in;
      end
    end
  end

  assign dump_busy = (state != IDLE) && (state != DONE);
  assign dump_done = (state == DONE);
  assign ram_en    = (state == RD || state == SEND || state == WAIT) ? (3'b001 << ch_q) : 3'b000;

`ifdef DUMP_CHKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum <= '0;
    else if (state == IDLE) sum <= '0;
    else if (state == SEND) sum <= sum + corrected;
  end

  assign send_resp = (state == SEND) || (state == CHK);
  assign chk_sel   = (state == CHK) || (state == CHK_WAIT);
  assign chk_byte  = sum;
`else
  logic unused_corrected;
  assign unused_corrected = ^corrected;
  assign send_resp = (state == SEND);
`endif

endmodule

// File: tb/tb_dump_sequencer.sv
// tb/tb_dump_sequencer.sv - Directed vector bench for dump_sequencer with SPI and UART responders.
// Optional feature macro: DUMP_CHKSUM_EN (enables checksum byte checks).
`timescale 1ns/1ps
module tb_dump_sequencer;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  typedef struct {
    logic [1:0]        ch;
    logic [8:0]        gains;
    logic [ADDR_W-1:0] te;
    logic [15:0]       off_w;
    logic [15:0]       gn_w;
    logic [ADDR_W-1:0] faddr;
    logic [2:0]        en;
  } vec_t;

  logic              clk, rst_n, dump, SPI_done, resp_sent;
  logic [1:0]        dump_ch;
  logic [8:0]        ch_gain;
  logic [ADDR_W-1:0] trace_end;
  logic [7:0]        corrected;
  logic              wrt_SPI, flopOffset, flopGain, send_resp, dump_busy, dump_done;
  logic [15:0]       SPI_data;
  logic [2:0]        ss, ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              chk_now;
  logic [7:0]        chk_byte_w;

  dump_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .dump(dump), .dump_ch(dump_ch), .ch_gain(ch_gain),
    .trace_end(trace_end), .SPI_done(SPI_done), .resp_sent(resp_sent), .corrected(corrected),
    .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .ss(ss), .flopOffset(flopOffset),
    .flopGain(flopGain), .ram_addr(ram_addr), .ram_en(ram_en), .send_resp(send_resp),
    .dump_busy(dump_busy),
`ifdef DUMP_CHKSUM_EN
    .chk_sel(chk_now), .chk_byte(chk_byte_w),
`endif
    .dump_done(dump_done)
  );

`ifndef DUMP_CHKSUM_EN
  assign chk_now    = 1'b0;
  assign chk_byte_w = 8'h00;
`endif

  int n_checks, n_err, cyc;
  int ev[$];
  int n_send, n_done, n_chk, addr_err, en_err;
  int gain_cyc, first_send_cyc, done_cyc, chk_cyc;
  logic [ADDR_W-1:0] first_addr, prev_addr;
  logic [2:0] exp_en;
  logic [7:0] chk_val;
  bit busy_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    SPI_done = 1'b0;
    forever begin
      @(negedge clk);
      SPI_done = 1'b0;
      if (wrt_SPI) begin
        repeat (3) @(negedge clk);
        SPI_done = 1'b1;
      end
    end
  end

  initial begin
    resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      resp_sent = 1'b0;
      if (send_resp) begin
        repeat (3) @(negedge clk);
        resp_sent = 1'b1;
      end
    end
  end

  // Event log: offset/gain flop pulses are logged before a same-cycle SPI word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dump_busy) busy_seen = 1'b1;
        if (flopOffset) ev.push_back(32'h10000);
        if (flopGain) begin
          ev.push_back(32'h20000);
          gain_cyc = cyc;
        end
        if (wrt_SPI) ev.push_back({16'h0000, SPI_data});
        if (dump_done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (send_resp && chk_now) begin
          n_chk++;
          chk_val = chk_byte_w;
          chk_cyc = cyc;
        end else if (send_resp) begin
          if (n_send == 0) begin
            first_addr     = ram_addr;
            first_send_cyc = cyc;
          end else if (ram_addr != ADDR_W'(prev_addr + 1'b1)) begin
            addr_err++;
          end
          if (ram_en != exp_en) en_err++;
          prev_addr = ram_addr;
          n_send++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    ev.delete();
    n_send = 0; n_done = 0; n_chk = 0; addr_err = 0; en_err = 0;
    gain_cyc = 0; first_send_cyc = 0; done_cyc = 0; chk_cyc = 0;
    busy_seen = 1'b0;
  endtask

  task automatic check_idle_outputs(input string t);
    check($sformatf("%s wrt_SPI", t), 32'(wrt_SPI), 0);
    check($sformatf("%s SPI_data", t), 32'(SPI_data), 0);
    check($sformatf("%s ss", t), 32'(ss), 32'h4);
    check($sformatf("%s flopOffset", t), 32'(flopOffset), 0);
    check($sformatf("%s flopGain", t), 32'(flopGain), 0);
    check($sformatf("%s ram_addr", t), 32'(ram_addr), 0);
    check($sformatf("%s ram_en", t), 32'(ram_en), 0);
    check($sformatf("%s send_resp", t), 32'(send_resp), 0);
    check($sformatf("%s dump_busy", t), 32'(dump_busy), 0);
    check($sformatf("%s dump_done", t), 32'(dump_done), 0);
  endtask

  task automatic start_dump(input vec_t v, input string t);
    @(negedge clk);
    clear_log();
    exp_en    = v.en;
    dump_ch   = v.ch;
    ch_gain   = v.gains;
    trace_end = v.te;
    dump      = 1'b1;
    @(negedge clk);
    dump = 1'b0;
    check($sformatf("%s wrt_SPI 1 cycle after dump", t), 32'(wrt_SPI), 1);
    check($sformatf("%s busy after dump", t), 32'(dump_busy), 1);
  endtask

  task automatic finish_dump(input bit inject);
    bit injected;
    injected = 1'b0;
    for (int i = 0; i < 20000 && n_done == 0; i++) begin
      @(negedge clk);
      if (inject && !injected && ram_en != 3'b000) begin
        dump_ch  = 2'b00;
        dump     = 1'b1;
        injected = 1'b1;
        @(negedge clk);
        dump = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_dump(input vec_t v, input string t);
    int exp_ev[6];
    exp_ev = '{int'(v.off_w), 0, 32'h10000, int'(v.gn_w), 0, 32'h20000};
    check($sformatf("%s event count", t), 32'(ev.size()), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s event %0d", t, k), (k < ev.size()) ? ev[k] : 32'hdead, exp_ev[k]);
    check($sformatf("%s first ram_addr", t), 32'(first_addr), 32'(v.faddr));
    check($sformatf("%s ram_addr steps", t), 32'(addr_err), 0);
    check($sformatf("%s ram_en at send", t), 32'(en_err), 0);
    check($sformatf("%s flopGain to send_resp", t), 32'(first_send_cyc - gain_cyc), 1);
    check($sformatf("%s samples sent", t), 32'(n_send), DEPTH);
    check($sformatf("%s dump_done pulses", t), 32'(n_done), 1);
    check($sformatf("%s busy after done", t), 32'(dump_busy), 0);
`ifdef DUMP_CHKSUM_EN
    check($sformatf("%s checksum bytes", t), 32'(n_chk), 1);
    check($sformatf("%s checksum value", t), 32'(chk_val), (DEPTH * int'(corrected)) % 256);
    check($sformatf("%s done after checksum", t), 32'(done_cyc > chk_cyc), 1);
`endif
  endtask

  initial begin
    vec_t vecs[3];
    n_checks = 0; n_err = 0;
    rst_n = 1'b0; dump = 1'b0; dump_ch = 2'b00; ch_gain = '0; trace_end = '0;
    corrected = 8'h03; exp_en = 3'b000;
    clear_log();

    vecs[0] = '{ch: 2'd1, gains: {3'b111, 3'b101, 3'b010}, te: 9'd100,
                off_w: 16'h1A00, gn_w: 16'h1B00, faddr: 9'd101, en: 3'b010};
    vecs[1] = '{ch: 2'd0, gains: {3'b111, 3'b101, 3'b010}, te: 9'd511,
                off_w: 16'h0400, gn_w: 16'h0500, faddr: 9'd0, en: 3'b001};
    vecs[2] = '{ch: 2'd2, gains: {3'b111, 3'b000, 3'b001}, te: 9'd0,
                off_w: 16'h2E00, gn_w: 16'h2F00, faddr: 9'd1, en: 3'b100};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      start_dump(vecs[i], $sformatf("vec%0d", i));
      finish_dump(1'b0);
      check_dump(vecs[i], $sformatf("vec%0d", i));
    end

    @(negedge clk);
    clear_log();
    dump_ch = 2'b11;
    dump    = 1'b1;
    @(negedge clk);
    dump = 1'b0;
    repeat (20) @(negedge clk);
    check("illegal ch SPI events", 32'(ev.size()), 0);
    check("illegal ch busy seen", 32'(busy_seen), 0);
    check("illegal ch dump_done", 32'(n_done), 0);

    start_dump(vecs[0], "redump");
    finish_dump(1'b1);
    check_dump(vecs[0], "redump");

    start_dump(vecs[0], "midreset");
    for (int i = 0; i < 5000 && n_send < 37; i++) @(negedge clk);
    @(negedge clk);
    check("midreset samples before reset", 32'(n_send), 37);
    check("midreset ram_en in WAIT", 32'(ram_en), 32'(vecs[0].en));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_dump(vecs[2], "after_reset");
    finish_dump(1'b0);
    check_dump(vecs[2], "after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
